img_line_window: RTL and testbench
==================================

# img_line_window

Streaming line buffer for the scanner's image path. Pixels arrive one per cycle in raster order. For each pixel, the block outputs a vertical column of `TAPS` pixels at the same x-position: the current pixel plus the `TAPS-1` pixels directly above it. It sits between the camera pixel stream and the vertical/2-D filters of the laser-line detector, and replaces the single-line BRAM with a parametrised multi-line ring of block RAMs.

## Interface
- `WIDTH`, 8: bits per pixel.
- `LINE_LEN`, 640: pixels per line.
- `ADDR_W`, 10: x-address width.
  - Requires 2^ADDR_W >= LINE_LEN.
- `TAPS`, 3: column height, including the current pixel.
  - Range 2..8.
  - Uses TAPS-1 BRAM banks, each LINE_LEN x WIDTH.
- `clk` input, 1: single clock; all logic is on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `frame_start` input, 1: synchronous, one-cycle pulse that restarts line/row tracking.
- `pix_valid` input, 1: `pix_in` is valid this cycle.
- `pix_in` input, WIDTH: incoming pixel.
- `out_valid` output, 1: `out_col` is valid.
- `out_col` output, TAPS*WIDTH: the output column.
  - Slice k (bits [k*WIDTH +: WIDTH]) holds the pixel from k lines ago.
  - Slice 0 is the current pixel.
- `out_x` output, ADDR_W: x-position of the column.
- `out_line_end` output, 1: the column is the last pixel of its line (x = LINE_LEN-1).
- `out_full` output, 1: all TAPS slices hold real data (rows_filled = TAPS-1).

## Operation
- **Counters:**
  - `x` counts 0..LINE_LEN-1 and advances on each `pix_valid`.
  - On an accepted pixel with x = LINE_LEN-1, `x` wraps to 0 and `wr_bank` advances modulo TAPS-1.
  - `rows_filled` also increments at that point, saturating at TAPS-1.
- **Per accepted pixel:**
  - All TAPS-1 banks are read at address `x`.
  - In the same cycle, `pix_in` is written into bank `wr_bank` at `x`.
  - Banks are read-before-write: the bank being written returns its old contents, which is the line TAPS-1 ago.
- **Column assembly (output register stage):**
  - Slice 0 = registered `pix_in`.
  - Slice k (k >= 1) = data from bank (wr_bank_q - k) mod (TAPS-1), where `wr_bank_q` is `wr_bank` registered alongside the read.
- **Masking:** slice k outputs 0 whenever k > rows_filled_q, where `rows_filled_q` is the value at read time. Stale BRAM contents therefore never appear.
- **frame_start:**
  - Clears `x`, `wr_bank` and `rows_filled`.
  - If `pix_valid` is high in the same cycle, that pixel is x=0 of the new frame and is written to bank 0.
  - BRAM contents are not cleared; masking hides them.
- **Idle:** with `pix_valid` low, all state holds, no BRAM write occurs, and `out_valid` goes low the following cycle.
- **Reset (`rst_n` low):**
  - `x`, `wr_bank`, `rows_filled` and all output registers go to 0 immediately.
  - `out_valid`, `out_full` and `out_line_end` read 0.
  - BRAM contents are undefined, and the BRAM itself has no reset.

## Timing
- Latency is exactly 1 cycle, pixel in to column out:
  - `out_valid` is `pix_valid` delayed by one cycle.
  - `out_x`, `out_line_end` and `out_full` are aligned with `out_col`.
- Throughput is one pixel per clock. Arbitrary `pix_valid` gaps are allowed, with no backpressure.
- A pixel written at x in line n appears in slice k exactly when line n+k reaches x.
- Reset release: the first accepted pixel after `rst_n` rises is x=0 of row 0.
- `frame_start` coinciding with x = LINE_LEN-1: `frame_start` wins. There is no bank advance beyond the clear, and `out_line_end` still reflects the pixel that was accepted.

## Test plan
1. **Basic window:** TAPS=3, LINE_LEN=8, continuous ramp pix = row*16 + x for 4 rows.
   - Row 2, x=5: `out_col` = {0x05, 0x15, 0x25} (slices 2, 1, 0), `out_full`=1, `out_x`=5.
   - `out_line_end`=1 only at x=7.
2. **Fill masking** (same stimulus as scenario 1):
   - Row 0: slices 1 and 2 are 0, `out_full`=0.
   - Row 1, x=3: `out_col` = {0x00, 0x03, 0x13}, `out_full`=0.
   - Row 2 onward: `out_full`=1.
3. **Bubbles:** same data with `pix_valid` pattern 1,0,0,1,0,1...
   - Column values are identical to scenario 1.
   - `out_valid` is the input pattern shifted one cycle.
4. **Bank wrap:** TAPS=4, 10 rows.
   - Row 9, x=2: `out_col` = {0x62, 0x72, 0x82, 0x92}.
5. **frame_start mid-line:** pulse at row 4, x=3, with `pix_valid`=1 and pix=0xAA.
   - Output: `out_x`=0, `out_col` = {0, 0, 0xAA}, `out_full`=0.
   - Row 0 masking then behaves as in scenario 2.
6. **Async reset mid-line:** drop `rst_n` between edges during row 3.
   - `out_valid`, `out_full`, `out_line_end` and `out_col` read 0 before the next edge.
   - After release, the first pixel reports `out_x`=0 with upper slices 0.

Source files
------------

// File: rtl/img_line_window.sv
// Streaming vertical window: one pixel per cycle in, a TAPS-high column out one cycle later.
// Previous lines sit in a ring of TAPS-1 line banks that are read before they are written.

module img_line_bank #(
  parameter int WIDTH    = 8,
  parameter int LINE_LEN = 640,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [0:LINE_LEN-1];
  logic [WIDTH-1:0] rd_q;

  // Read and write share the enable; the read captures the old word at the written address.
  always_ff @(posedge clk) begin
    if (en) begin
      rd_q <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

  assign rdata = rd_q;
endmodule

module img_line_window #(
  parameter int WIDTH    = 8,
  parameter int LINE_LEN = 640,
  parameter int ADDR_W   = 10,
  parameter int TAPS     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    pix_valid,
  input  logic [WIDTH-1:0]        pix_in,
  output logic                    out_valid,
  output logic [TAPS*WIDTH-1:0]   out_col,
  output logic [ADDR_W-1:0]       out_x,
  output logic                    out_line_end,
  output logic                    out_full
);
  localparam int NB = TAPS - 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW = $clog2(TAPS);

  logic [ADDR_W-1:0] x_q, x_d, x_e;
  logic [BW-1:0]     bank_q, bank_d, bank_e;
  logic [RW-1:0]     rows_q, rows_d, rows_e;
  logic              last;

  // Output stage, captured alongside the bank read
  logic              vld_q, vld_d;
  logic [WIDTH-1:0]  pix_q, pix_d;
  logic [ADDR_W-1:0] xo_q, xo_d;
  logic              le_q, le_d;
  logic [BW-1:0]     banko_q, banko_d;
  logic [RW-1:0]     rowso_q, rowso_d;

  logic [NB-1:0][WIDTH-1:0]   rd_data;
  logic [NB-1:0]              bank_we;
  logic [TAPS-1:0][WIDTH-1:0] col;

  // frame_start makes the pixel of the same cycle x=0 of row 0, bank 0.
  always_comb begin
    x_e    = frame_start ? '0 : x_q;
    bank_e = frame_start ? '0 : bank_q;
    rows_e = frame_start ? '0 : rows_q;
    last   = (x_e == ADDR_W'(LINE_LEN - 1));
  end

  always_comb begin
    x_d     = x_q;
    bank_d  = bank_q;
    rows_d  = rows_q;
    vld_d   = pix_valid;
    pix_d   = pix_q;
    xo_d    = xo_q;
    le_d    = le_q;
    banko_d = banko_q;
    rowso_d = rowso_q;
    if (pix_valid) begin
      x_d     = last ? '0 : x_e + ADDR_W'(1);
      bank_d  = bank_e;
      rows_d  = rows_e;
      if (last) begin
        bank_d = (bank_e == BW'(NB - 1)) ? '0 : bank_e + BW'(1);
        if (rows_e != RW'(NB)) rows_d = rows_e + RW'(1);
      end
      pix_d   = pix_in;
      xo_d    = x_e;
      le_d    = last;
      banko_d = bank_e;
      rowso_d = rows_e;
    end else if (frame_start) begin
      x_d    = '0;
      bank_d = '0;
      rows_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      bank_q  <= '0;
      rows_q  <= '0;
      vld_q   <= 1'b0;
      pix_q   <= '0;
      xo_q    <= '0;
      le_q    <= 1'b0;
      banko_q <= '0;
      rowso_q <= '0;
    end else begin
      x_q     <= x_d;
      bank_q  <= bank_d;
      rows_q  <= rows_d;
      vld_q   <= vld_d;
      pix_q   <= pix_d;
      xo_q    <= xo_d;
      le_q    <= le_d;
      banko_q <= banko_d;
      rowso_q <= rowso_d;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign bank_we[b] = pix_valid && (bank_e == BW'(b));
    img_line_bank #(
      .WIDTH(WIDTH), .LINE_LEN(LINE_LEN), .ADDR_W(ADDR_W)
    ) u_bank (
      .clk   (clk),
      .en    (pix_valid),
      .we    (bank_we[b]),
      .addr  (x_e),
      .wdata (pix_in),
      .rdata (rd_data[b])
    );
  end

  // Slice k comes from the bank written k lines back; rows not yet filled read as zero.
  always_comb begin
    int idx;
    col    = '0;
    col[0] = pix_q;
    for (int k = 1; k < TAPS; k++) begin
      idx = int'(banko_q) + NB - k;
      if (idx >= NB) idx = idx - NB;
      if (rowso_q >= RW'(k)) col[k] = rd_data[BW'(idx)];
    end
  end

  assign out_valid    = vld_q;
  assign out_col      = col;
  assign out_x        = xo_q;
  assign out_line_end = le_q;
  assign out_full     = (rowso_q == RW'(NB));
endmodule

// File: tb/tb_img_line_window.sv
// Drives a TAPS=3 and a TAPS=4 window with the same stream and checks both
// against a frame-history model: slice k = pixel at (row-k, x) once that row exists.

module tb_img_line_window;
  localparam int W = 8, LL = 8, AW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic frame_start = 1'b0, pix_valid = 1'b0;
  logic [W-1:0] pix_in = '0;

  logic          v3, le3, f3, v4, le4, f4;
  logic [23:0]   col3;
  logic [31:0]   col4;
  logic [AW-1:0] x3, x4;

  always #5 clk = ~clk;

  img_line_window #(.WIDTH(W), .LINE_LEN(LL), .ADDR_W(AW), .TAPS(3)) u3 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_in(pix_in), .out_valid(v3), .out_col(col3), .out_x(x3),
    .out_line_end(le3), .out_full(f3));

  img_line_window #(.WIDTH(W), .LINE_LEN(LL), .ADDR_W(AW), .TAPS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_in(pix_in), .out_valid(v4), .out_col(col4), .out_x(x4),
    .out_line_end(le4), .out_full(f4));

  int tests = 0, fails = 0;
  logic [7:0] hist [0:63][0:LL-1];
  int row = 0, xm = 0, lrow = 0, lx = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_col(input int taps);
    logic [63:0] c = '0;
    for (int k = 0; k < taps; k++)
      if (k <= row) c[k*8 +: 8] = hist[(row - k) % 64][xm];
    return c;
  endfunction

  // One clock: drive, update the model, then sample 1 time unit after the edge.
  task automatic cyc(input bit v, input bit fs, input logic [7:0] p);
    logic [63:0] e3, e4;
    int ex;
    bit ele, ef3, ef4;
    e3 = '0; e4 = '0; ex = 0; ele = 0; ef3 = 0; ef4 = 0;
    pix_valid = v; frame_start = fs; pix_in = p;
    if (fs) begin row = 0; xm = 0; end
    if (v) begin
      hist[row % 64][xm] = p;
      e3 = exp_col(3); e4 = exp_col(4);
      ex = xm; ele = (xm == LL - 1); ef3 = (row >= 2); ef4 = (row >= 3);
      lrow = row; lx = xm;
      xm++;
      if (xm == LL) begin xm = 0; row++; end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0; frame_start = 1'b0;
    chk("valid3", 64'(v3), 64'(v));
    chk("valid4", 64'(v4), 64'(v));
    if (v) begin
      chk("col3", 64'(col3), e3);
      chk("col4", 64'(col4), e4);
      chk("x3", 64'(x3), 64'(ex));
      chk("x4", 64'(x4), 64'(ex));
      chk("le3", 64'(le3), 64'(ele));
      chk("le4", 64'(le4), 64'(ele));
      chk("full3", 64'(f3), 64'(ef3));
      chk("full4", 64'(f4), 64'(ef4));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v"}, {62'b0, v3, v4}, 64'h0);
    chk({tag, "_f"}, {62'b0, f3, f4}, 64'h0);
    chk({tag, "_le"}, {62'b0, le3, le4}, 64'h0);
    chk({tag, "_col"}, {8'h0, col3, col4}, 64'h0);
  endtask

  task automatic ramp(input int rows, input bit bubbles);
    int gaps [3] = '{0, 2, 1};
    int g = 0;
    for (int r = 0; r < rows; r++)
      for (int xx = 0; xx < LL; xx++) begin
        if (bubbles) begin
          for (int i = 0; i < gaps[g]; i++) cyc(0, 0, 8'h00);
          g = (g + 1) % 3;
        end
        cyc(1, 0, 8'(r * 16 + xx));
        if (lrow == 2 && lx == 5) chk("s1_r2x5", 64'(col3), 64'h051525);
        if (lrow == 1 && lx == 3) chk("s2_r1x3", 64'(col3), 64'h000313);
        if (lrow == 0) chk("s2_row0_upper", 64'(col3[23:8]), 64'h0);
        if (lrow == 9 && lx == 2) chk("s4_r9x2", 64'(col4), 64'h62728292);
      end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Continuous ramp straight out of reset, then with bubbles.
    ramp(4, 0);
    cyc(0, 1, 8'h00);
    ramp(4, 1);

    // Long run exercising the TAPS=4 bank wrap.
    cyc(0, 1, 8'h00);
    ramp(10, 0);

    // frame_start mid-line with a pixel in the same cycle.
    cyc(0, 1, 8'h00);
    ramp(4, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'($urandom));
    cyc(1, 1, 8'hAA);
    chk("fs_col3", 64'(col3), 64'h0000AA);
    chk("fs_x3", 64'(x3), 64'h0);
    chk("fs_full3", 64'(f3), 64'h0);
    for (int i = 0; i < 2 * LL; i++) cyc(1, 0, 8'($urandom));

    // frame_start landing on the last pixel of a line.
    while (xm != LL - 1) cyc(1, 0, 8'($urandom));
    cyc(1, 1, 8'h5C);
    chk("fs_eol_le", 64'(le3), 64'h0);
    chk("fs_eol_x", 64'(x4), 64'h0);

    // Random traffic with gaps and occasional frame restarts.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, 8'($urandom));

    // Asynchronous reset during row 3.
    cyc(0, 1, 8'h00);
    ramp(3, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'($urandom));
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    @(posedge clk); #1;
    chk_zero("arst_hold");
    rst_n = 1'b1;
    row = 0; xm = 0;
    cyc(1, 0, 8'h3C);
    chk("arst_x", 64'(x3), 64'h0);
    chk("arst_upper", {16'h0, col4[31:8]}, 64'h0);
    for (int i = 0; i < 3 * LL; i++) cyc(1, 0, 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
